// File: rtl/pixel_access_port.sv
// pixel_access_port
//   Host-side initiator for the frame-buffer memory manager. Host commands
//   (SET_X, SET_Y, WRITE_PIXEL, READ_PIXEL) are queued in a small FIFO and
//   executed strictly in order. Each pixel command becomes one memory read or
//   write transaction addressed by an X/Y cursor.
//
//   Optional feature macro: PIXEL_PORT_AUTO_INCREMENT_EN
//     defined   - cursor advances in raster order after every completed pixel op
//     undefined - cursor only changes through SET_X / SET_Y
//
// Ports
//   i_clock                 system clock, rising edge
//   i_reset                 asynchronous reset, active low
//   i_hostValid/o_hostReady host command handshake (push when both high)
//   i_hostCmd               0=SET_X 1=SET_Y 2=WRITE_PIXEL 3=READ_PIXEL
//   i_hostData              SET_X uses [8:0]; SET_Y/WRITE_PIXEL use [7:0]
//   o_readData/o_readValid  READ_PIXEL result, valid for one cycle
//   o_busy                  FIFO non-empty or transaction in flight
//   o_memory*               transaction address, data and request levels
//   i_memoryReadData        read result from the memory manager
//   i_memory*Complete       one-cycle completion pulses
module pixel_access_port #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_hostValid,
  output logic       o_hostReady,
  input  logic [1:0] i_hostCmd,
  input  logic [8:0] i_hostData,
  output logic [7:0] o_readData,
  output logic       o_readValid,
  output logic       o_busy,
  output logic [8:0] o_memoryXCoord,
  output logic [7:0] o_memoryYCoord,
  output logic       o_memoryReadRequest,
  output logic       o_memoryWriteRequest,
  output logic [7:0] o_memoryWriteData,
  input  logic [7:0] i_memoryReadData,
  input  logic       i_memoryReadComplete,
  input  logic       i_memoryWriteComplete
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [8:0]  X_LAST  = 9'(WIDTH - 1);
  localparam logic [7:0]  Y_LAST  = 8'(HEIGHT - 1);

  localparam logic [1:0] CMD_SET_X = 2'd0;
  localparam logic [1:0] CMD_SET_Y = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  typedef enum logic [1:0] {IDLE, WRITE_WAIT, READ_WAIT, RELEASE} state_t;

  // Command FIFO: {cmd[1:0], data[8:0]} per entry
  logic [10:0]   r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          r_host_ready;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head_cmd;
  logic [8:0]    w_head_data;

  state_t     r_state;
  state_t     w_state_next;
  logic       w_write_done;
  logic       w_read_done;

  logic [8:0] r_cursor_x;
  logic [7:0] r_cursor_y;
  logic [8:0] w_adv_x;
  logic [7:0] w_adv_y;

  logic [8:0] r_mem_x;
  logic [7:0] r_mem_y;
  logic [7:0] r_mem_wdata;
  logic       r_mem_rreq;
  logic       r_mem_wreq;
  logic [7:0] r_read_data;
  logic       r_read_valid;

  // hostReady is registered, so a full FIFO refuses a push even when the
  // head is popped in the same cycle.
  assign w_push       = i_hostValid && r_host_ready;
  assign w_head_cmd   = r_fifo_mem[r_rd_ptr][10:9];
  assign w_head_data  = r_fifo_mem[r_rd_ptr][8:0];
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge i_clock) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {i_hostCmd, i_hostData};
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_host_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count      <= w_count_next;
      r_host_ready <= (w_count_next != DEPTH_L);
    end
  end

`ifdef PIXEL_PORT_AUTO_INCREMENT_EN
  // Raster-order advance; (WIDTH-1, HEIGHT-1) wraps to (0,0)
  always_comb begin
    w_adv_x = r_cursor_x + 9'd1;
    w_adv_y = r_cursor_y;
    if (r_cursor_x == X_LAST) begin
      w_adv_x = '0;
      w_adv_y = (r_cursor_y == Y_LAST) ? 8'd0 : r_cursor_y + 8'd1;
    end
  end
`else
  assign w_adv_x = r_cursor_x;
  assign w_adv_y = r_cursor_y;
`endif

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_write_done = 1'b0;
    w_read_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head_cmd == CMD_WRITE) w_state_next = WRITE_WAIT;
          if (w_head_cmd == CMD_READ)  w_state_next = READ_WAIT;
        end
      end
      WRITE_WAIT: begin
        if (i_memoryWriteComplete) begin
          w_write_done = 1'b1;
          w_state_next = RELEASE;
        end
      end
      READ_WAIT: begin
        if (i_memoryReadComplete) begin
          w_read_done  = 1'b1;
          w_state_next = RELEASE;
        end
      end
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: cursor, transaction registers, read return
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cursor_x   <= '0;
      r_cursor_y   <= '0;
      r_mem_x      <= '0;
      r_mem_y      <= '0;
      r_mem_wdata  <= '0;
      r_mem_rreq   <= 1'b0;
      r_mem_wreq   <= 1'b0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      if (w_pop) begin
        case (w_head_cmd)
          CMD_SET_X: if (w_head_data <= X_LAST) r_cursor_x <= w_head_data;
          CMD_SET_Y: if (w_head_data[7:0] <= Y_LAST) r_cursor_y <= w_head_data[7:0];
          CMD_WRITE: begin
            r_mem_x     <= r_cursor_x;
            r_mem_y     <= r_cursor_y;
            r_mem_wdata <= w_head_data[7:0];
            r_mem_wreq  <= 1'b1;
          end
          default: begin
            r_mem_x    <= r_cursor_x;
            r_mem_y    <= r_cursor_y;
            r_mem_rreq <= 1'b1;
          end
        endcase
      end
      if (w_write_done || w_read_done) begin
        r_mem_wreq <= 1'b0;
        r_mem_rreq <= 1'b0;
        r_cursor_x <= w_adv_x;
        r_cursor_y <= w_adv_y;
      end
      if (w_read_done) begin
        r_read_data  <= i_memoryReadData;
        r_read_valid <= 1'b1;
      end
    end
  end

  assign o_hostReady          = r_host_ready;
  assign o_busy               = (r_count != '0) || (r_state != IDLE);
  assign o_readData           = r_read_data;
  assign o_readValid          = r_read_valid;
  assign o_memoryXCoord       = r_mem_x;
  assign o_memoryYCoord       = r_mem_y;
  assign o_memoryWriteData    = r_mem_wdata;
  assign o_memoryReadRequest  = r_mem_rreq;
  assign o_memoryWriteRequest = r_mem_wreq;

endmodule
